// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package alu181_pkg;

    // Width of one 74181 slice.
    localparam int NW = 4;

    // Function selects used by the control unit (S3..S0).
    localparam logic [3:0] S_ADD    = 4'b1001;  // M=0: A plus B
    localparam logic [3:0] S_SUB    = 4'b0110;  // M=0: A minus B minus 1 (Cn=0 gives A-B)
    localparam logic [3:0] S_XOR    = 4'b0110;  // M=1: A xor B
    localparam logic [3:0] S_PASS_A = 4'b1111;  // M=1: F = A

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/alu181_seq_slice.sv
// 4-bit 74181-style slice, active-high data, active-low carry in/out.
module ALU181
    import alu181_pkg::*;
(
    input  logic [NW-1:0] a_i,
    input  logic [NW-1:0] b_i,
    input  logic [3:0]    s_i,
    input  logic          m_i,
    input  logic          cn_i,
    output logic [NW-1:0] f_o,
    output logic          cn4_o
);

    logic [NW-1:0] p, g, h;
    logic [NW:0]   c;

    // Per-bit propagate/generate from the S-selected B terms, then ripple carry.
    always_comb begin
        p = a_i | (b_i & {NW{s_i[0]}}) | (~b_i & {NW{s_i[1]}});
        g = (a_i & ~b_i & {NW{s_i[2]}}) | (a_i & b_i & {NW{s_i[3]}});
        h = p ^ g;
        c = '0;
        c[0] = ~cn_i;
        for (int i = 0; i < NW; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        f_o   = m_i ? ~h : (h ^ c[NW-1:0]);
        cn4_o = ~c[NW];
    end

endmodule

// File: rtl/alu181_seq.sv
// Nibble-serial sequencer: runs a WIDTH-bit 74181 op through one slice, LSB first.
module alu181_seq
    import alu181_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NW * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             cin_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_n,
    output logic             eq,
    output logic             zero
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_n_q, cout_n_d;
    logic             eq_q, eq_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [NW-1:0]    slice_f;
    logic             slice_c4;
    logic             last;

    ALU181 u_slice (
        .a_i   (a_q[NW*idx_q +: NW]),
        .b_i   (b_q[NW*idx_q +: NW]),
        .s_i   (s_q),
        .m_i   (m_q),
        .cn_i  (carry_q),
        .f_o   (slice_f),
        .cn4_o (slice_c4)
    );

    assign last = (idx_q == IW'(NIBBLES - 1));

    // Next-state: latch on accept, fold one nibble per RUN cycle, flag on the last one.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        result_d = result_q;
        cout_n_d = cout_n_q;
        eq_d     = eq_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    s_d     = op_s;
                    m_d     = op_m;
                    carry_d = cin_n;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[NW*idx_q +: NW] = slice_f;
                carry_d = slice_c4;
                idx_d   = idx_q + IW'(1);
                if (last) begin
                    state_d  = IDLE;
                    idx_d    = '0;
                    done_d   = 1'b1;
                    // A logic-mode carry-out means nothing, so report "no carry".
                    cout_n_d = m_q ? 1'b1 : slice_c4;
                    eq_d     = &result_d;
                    zero_d   = ~|result_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            result_q <= '0;
            cout_n_q <= 1'b1;
            eq_q     <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            result_q <= result_d;
            cout_n_q <= cout_n_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign result = result_q;
    assign cout_n = cout_n_q;
    assign eq     = eq_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu181_seq.sv
// Scoreboard bench for alu181_seq: stimulus pushes expectations, monitor checks on done.
module tb_alu181_seq;
    import alu181_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, op_m, cin_n;
    logic [3:0]  op_s;
    logic [15:0] a, b;
    logic        busy, done, cout_n, eq, zero;
    logic [15:0] result;

    alu181_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_s(op_s), .op_m(op_m),
        .cin_n(cin_n), .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .cout_n(cout_n), .eq(eq), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic        c, e, z;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   npass = 0;
    int   ntotal = 0;
    int   bcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop an expectation on every done and compare flags, result and latency.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("cout_n", 32'(cout_n), 32'(e.c));
                chk("eq",     32'(eq),     32'(e.e));
                chk("zero",   32'(zero),   32'(e.z));
                chk("latency", 32'(cyc),   32'(e.cyc));
            end
        end
    end

    // Monitor: every uninterrupted busy window lasts exactly NIBBLES cycles.
    always @(negedge clk) begin
        if (rst) bcnt = 0;
        else if (busy) bcnt++;
        else if (bcnt != 0) begin
            chk("busy_len", 32'(bcnt), 32'(4));
            bcnt = 0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] s,
                         input logic m, input logic cn, input logic [15:0] er,
                         input logic ec, input logic ee, input logic ez);
        exp_t e;
        wait_idle();
        a = ia; b = ib; op_s = s; op_m = m; cin_n = cn; start = 1'b1;
        e.r = er; e.c = ec; e.e = ee; e.z = ez; e.cyc = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; op_s = 4'($urandom); op_m = 1'($urandom);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; start = 1'b0; op_s = '0; op_m = 1'b0; cin_n = 1'b1; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   32'(busy),   32'(0));
        chk("rst_done",   32'(done),   32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_cout_n", 32'(cout_n), 32'(1));
        chk("rst_eq",     32'(eq),     32'(0));
        chk("rst_zero",   32'(zero),   32'(1));
        rst = 1'b0;

        issue(16'h1234, 16'h0FFF, S_ADD,    1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, S_ADD,    1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        issue(16'h5000, 16'h0001, S_SUB,    1'b0, 1'b0, 16'h4FFF, 1'b0, 1'b0, 1'b0);
        issue(16'h0001, 16'h0002, S_SUB,    1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0);
        issue(16'hA5A5, 16'hFFFF, S_XOR,    1'b1, 1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        issue(16'h00F0, 16'h1234, S_PASS_A, 1'b1, 1'b0, 16'h00F0, 1'b1, 1'b0, 1'b0);

        // Start held for 10 cycles: ops accepted at i=0 and i=5 (the done cycle) only.
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            start = 1'b1;
            if (i == 0) begin
                a = 16'h0100; b = 16'h0011; op_s = S_ADD; op_m = 1'b0; cin_n = 1'b1;
                e.r = 16'h0111; e.c = 1'b1; e.e = 1'b0; e.z = 1'b0; e.cyc = cyc + 5;
                q.push_back(e);
            end else if (i == 5) begin
                a = 16'h2000; b = 16'h0345; op_s = S_ADD; op_m = 1'b0; cin_n = 1'b1;
                e.r = 16'h2345; e.c = 1'b1; e.e = 1'b0; e.z = 1'b0; e.cyc = cyc + 5;
                q.push_back(e);
            end else begin
                a = $urandom; b = $urandom; op_s = 4'($urandom);
                op_m = 1'($urandom); cin_n = 1'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;

        // Reset while nibble 2 of an add is in flight: no done may follow.
        wait_idle();
        a = 16'h1111; b = 16'h2222; op_s = S_ADD; op_m = 1'b0; cin_n = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",   32'(busy),   32'(0));
        chk("abort_done",   32'(done),   32'(0));
        chk("abort_result", 32'(result), 32'(0));
        chk("abort_cout_n", 32'(cout_n), 32'(1));
        rst = 1'b0;
        repeat (8) @(negedge clk);

        issue(16'h0F0F, 16'h00F1, S_ADD, 1'b0, 1'b0, 16'h1001, 1'b1, 1'b0, 1'b0);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'(0));
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
